// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: merges fixed-timing pipeline writebacks with
// long-latency results queued in a small FIFO, preserving write-after-write order.
module rf_wb_arbiter #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PWr,
    input  logic [4:0]  PA,
    input  logic [31:0] PD,
    output logic        PStall,
    input  logic        LValid,
    input  logic [4:0]  LA,
    input  logic [31:0] LD,
    output logic        LReady,
    input  logic [4:0]  QA,
    output logic        QPend,
    output logic        RFWr,
    output logic [4:0]  A3,
    output logic [31:0] WD
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned StW  = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CntW-1:0] CntFull   = CntW'(DEPTH);
    localparam logic [StW-1:0]  StarveMax = StW'(STARVE_MAX);

    logic [4:0]      addr_q [DEPTH];
    logic [4:0]      addr_d [DEPTH];
    logic [31:0]     data_q [DEPTH];
    logic [31:0]     data_d [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [StW-1:0]  starve_q, starve_d;
    logic            rfwr_q, rfwr_d;
    logic [4:0]      a3_q, a3_d;
    logic [31:0]     wd_q, wd_d;

    logic full, empty, head_live, pipe_req, stall, lready;
    logic push, pop, pipe_win, head_win, qpend;

    // Arbitration decisions for the current cycle
    always_comb begin
        full      = (count_q == CntFull);
        empty     = (count_q == '0);
        head_live = !empty && live_q[rd_ptr_q];
        pipe_req  = PWr && (PA != 5'd0);
        stall     = !rst && (starve_q == StarveMax) && head_live;
        lready    = !full && !rst;
        push      = LValid && lready && (LA != 5'd0);
        pipe_win  = pipe_req && !stall;
        head_win  = stall || (head_live && !pipe_req);
        // A dead head drains silently alongside any pipe winner
        pop       = head_win || (!empty && !live_q[rd_ptr_q]);
    end

    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        live_d   = live_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        starve_d = starve_q;
        rfwr_d   = 1'b0;
        a3_d     = a3_q;
        wd_d     = wd_q;

        // Older queued writes to the same register are superseded by the pipe write
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (pipe_win && (addr_q[PtrW'(i)] == PA)) begin
                live_d[PtrW'(i)] = 1'b0;
            end
        end

        if (pop) begin
            live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = rd_ptr_q + PtrW'(1);
        end

        // Same-cycle enqueue is newer than the pipe write, so it is set after the kill
        if (push) begin
            addr_d[wr_ptr_q] = LA;
            data_d[wr_ptr_q] = LD;
            live_d[wr_ptr_q] = 1'b1;
            wr_ptr_d         = wr_ptr_q + PtrW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        if (pop) begin
            starve_d = '0;
        end else if (head_live && pipe_win && (starve_q != StarveMax)) begin
            starve_d = starve_q + StW'(1);
        end

        if (head_win) begin
            rfwr_d = 1'b1;
            a3_d   = addr_q[rd_ptr_q];
            wd_d   = data_q[rd_ptr_q];
        end else if (pipe_win) begin
            rfwr_d = 1'b1;
            a3_d   = PA;
            wd_d   = PD;
        end
    end

    always_comb begin
        qpend = 1'b0;
        if (!rst && (QA != 5'd0)) begin
            if (rfwr_q && (a3_q == QA)) begin
                qpend = 1'b1;
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (live_q[PtrW'(i)] && (addr_q[PtrW'(i)] == QA)) begin
                    qpend = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            live_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            rfwr_q   <= 1'b0;
            a3_q     <= '0;
            wd_q     <= '0;
        end else begin
            live_q   <= live_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            rfwr_q   <= rfwr_d;
            a3_q     <= a3_d;
            wd_q     <= wd_d;
        end
    end

    // Payload storage needs no reset; validity lives in live_q and count_q
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    assign PStall = stall;
    assign LReady = lready;
    assign QPend  = qpend;
    assign RFWr   = rfwr_q;
    assign A3     = a3_q;
    assign WD     = wd_q;

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Write-side front end of the register file: owns the single RF write port (RFWr/A3/WD).
- Merges two write sources:
  - in-order pipeline writeback (fixed timing, highest priority);
  - long-latency results (mul/div, late loads) arriving via valid/ready into a small FIFO.
- Preserves write-after-write order and exposes a pending-write query for the ID-stage hazard logic.

Parameters:
DEPTH, 4, long-latency FIFO entries (power of 2, >=2)
STARVE_MAX, 3, consecutive cycles a live FIFO head may lose to the pipeline before the pipeline is stalled

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous reset, active-high
PWr  input  1  pipeline writeback request
PA  input  5  pipeline destination register
PD  input  32  pipeline write data
PStall  output  1  pipeline writeback not accepted this cycle; pipeline holds PWr/PA/PD stable
LValid  input  1  long-latency result valid
LA  input  5  long-latency destination register
LD  input  32  long-latency data
LReady  output  1  FIFO can accept; transfer when LValid && LReady
QA  input  5  query register (ID stage)
QPend  output  1  live pending write to QA exists in FIFO or output stage
RFWr  output  1  registered RF write enable
A3  output  5  registered RF write address
WD  output  32  registered RF write data

Behaviour:
- Reset (rst=1 at posedge):
  - RFWr=0, A3=0, WD=0.
  - FIFO empty, all live bits cleared, starve counter=0.
  - While rst=1: LReady=0, PStall=0, QPend=0.
- Definitions:
  - Pipe request valid: PWr && PA!=0.
  - PWr with PA==0: accepted, produces no RF write, kills nothing.
- LReady = !full && !rst. No same-cycle pop credit: a full FIFO refuses even when popping.
- Enqueue:
  - LValid && LReady && LA!=0 → push {LA, LD, live=1}.
  - LValid && LReady && LA==0 → handshake completes, nothing stored.
- Per-cycle arbitration, one winner into output stage:
  - PStall = (starve==STARVE_MAX) && head live && FIFO non-empty.
  - PStall=1: live FIFO head wins, pops; pipe write not accepted.
  - Else if pipe request valid: pipe wins.
  - Else if live head exists: head pops and wins.
  - Else: no write.
- Dead head pops unconditionally each cycle without an RF write, in parallel with any pipe winner. At most one pop per cycle.
- Output stage: next cycle RFWr=1, A3/WD = winner's address/data; otherwise RFWr=0 and A3/WD hold. Latency is one cycle from acceptance to RFWr.
- Starve counter:
  - Increments (saturating at STARVE_MAX) when a live head exists and the pipe wins.
  - Clears on any pop.
  - Holds otherwise.
- WAW kill: an accepted pipe write to X!=0 clears live on every FIFO entry with address X. Exception: an entry enqueued in the same cycle with LA==X is newer and stays live.
- QPend = (RFWr && A3==QA) || any live FIFO entry with address==QA. QA==0 → QPend=0. Combinational.
- Pointers wrap modulo DEPTH. full/empty come from an occupancy count 0..DEPTH.
- Simultaneous push and pop with FIFO non-full and non-empty: occupancy unchanged.
- Push into an empty FIFO is not bypassed: earliest pop is the next cycle.
- rst mid-operation discards all FIFO contents and any in-flight output write.

Test Plan:
- Reset then idle → RFWr=0, A3=0, WD=0, LReady=1, PStall=0, QPend=0.
- PWr=1, PA=5, PD=0x1234 for one cycle → next cycle RFWr=1, A3=5, WD=0x1234; QPend(QA=5)=1 in that cycle only.
- Push LA=7/0xAA, LA=8/0xBB with PWr=0 → RF writes reg7=0xAA then reg8=0xBB on consecutive cycles; 4 pushes with PWr held at reg3 → LReady=0 at occupancy 4, 5th LValid not accepted.
- Push LA=9/0x11, then PWr to reg9=0x22 → RF sees a reg9=0x22 write only (dead entry pops silently); QPend(QA=9) drops once the 0x22 write leaves the output stage.
- FIFO holds LA=4, PWr asserted every cycle (PA=6) → pipe wins 3 cycles; 4th cycle PStall=1 and reg4 written; next cycle PStall=0 and held reg6 accepted.
- Same cycle: LValid LA=10/0x1 and PWr PA=10/0x2 → pipe write 0x2 first, then 0x1 (entry stays live); final reg10=0x1.
